uart_tx: RTL and testbench

Byte-wide UART transmitter: the transmit-side counterpart of `uart_rx`, returning `sobel_applier` output bytes to the host over the serial line. It accepts bytes through a valid/ready handshake into a one-entry holding register and serialises them as 8N1 frames, LSB first, on `RsTx`. It generates its own bit timing from `CLK_FREQ`/`BAUD_RATE` and drives `ready_out` to throttle the upstream stream, replacing the bench-side pulse emulation.

---
 rtl/uart_tx.sv | 178 +++++++++++++++++
 tb/tb_uart_tx.sv | 319 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/uart_tx.sv
// uart_tx: byte-wide UART transmitter, one-entry holding register, LSB-first serial frames.
// Define UART_TX_PARITY_EN to add an even-parity bit (start, 8 data, parity, stop).
module uart_tx #(
  parameter int CLK_FREQ  = 100_000_000,
  parameter int BAUD_RATE = 3_000_000
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [7:0] data_in,
  input  logic       valid_in,
  output logic       ready_out,
  output logic       RsTx,
  output logic       busy
);

  localparam int BAUD_DIV = (CLK_FREQ + BAUD_RATE / 2) / BAUD_RATE;
  localparam int TW       = (BAUD_DIV < 2) ? 1 : $clog2(BAUD_DIV);
  localparam logic [TW-1:0] LAST_TICK = TW'(BAUD_DIV - 1);

  if (BAUD_DIV < 2) begin : gen_div_check
    $error("uart_tx: BAUD_DIV must be at least 2");
  end

`ifdef UART_TX_PARITY_EN
  typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} state_e;
`else
  typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_e;
`endif

  state_e          state_q, state_d;
  logic [TW-1:0]   timer_q, timer_d;
  logic [2:0]      idx_q, idx_d;
  logic [7:0]      shift_q, shift_d;
  logic [7:0]      holdData_q, holdData_d;
  logic            holdValid_q, holdValid_d;
  logic            txd_q, txd_d;
  logic            ready_q, ready_d;
  logic            busy_q, busy_d;
  logic            accept, periodEnd, load;
`ifdef UART_TX_PARITY_EN
  logic            parity_q, parity_d;
`endif

  assign accept    = valid_in && ready_q;
  assign periodEnd = (timer_q == LAST_TICK);

  always_comb begin
    state_d     = state_q;
    timer_d     = timer_q;
    idx_d       = idx_q;
    shift_d     = shift_q;
    holdData_d  = holdData_q;
    holdValid_d = holdValid_q;
    txd_d       = txd_q;
    load        = 1'b0;
`ifdef UART_TX_PARITY_EN
    parity_d    = parity_q;
`endif

    case (state_q)
      IDLE: load = holdValid_q;
      START: begin
        if (periodEnd) begin
          state_d = DATA;
          timer_d = '0;
          idx_d   = 3'd0;
          txd_d   = shift_q[0];
        end else begin
          timer_d = timer_q + 1'b1;
        end
      end
      DATA: begin
        if (periodEnd) begin
          timer_d = '0;
          shift_d = shift_q >> 1;
          if (idx_q == 3'd7) begin
`ifdef UART_TX_PARITY_EN
            state_d = PARITY;
            txd_d   = parity_q;
`else
            state_d = STOP;
            txd_d   = 1'b1;
`endif
          end else begin
            idx_d = idx_q + 3'd1;
            txd_d = shift_q[1];
          end
        end else begin
          timer_d = timer_q + 1'b1;
        end
      end
`ifdef UART_TX_PARITY_EN
      PARITY: begin
        if (periodEnd) begin
          state_d = STOP;
          timer_d = '0;
          txd_d   = 1'b1;
        end else begin
          timer_d = timer_q + 1'b1;
        end
      end
`endif
      STOP: begin
        if (periodEnd) begin
          timer_d = '0;
          if (holdValid_q) begin
            load = 1'b1;
          end else begin
            state_d = IDLE;
            txd_d   = 1'b1;
          end
        end else begin
          timer_d = timer_q + 1'b1;
        end
      end
      default: begin
        state_d = IDLE;
        txd_d   = 1'b1;
      end
    endcase

    // Moving the held byte into the shifter starts a frame; it wins over the plain STOP->IDLE exit.
    if (load) begin
      shift_d     = holdData_q;
      state_d     = START;
      timer_d     = '0;
      idx_d       = 3'd0;
      txd_d       = 1'b0;
      holdValid_d = 1'b0;
`ifdef UART_TX_PARITY_EN
      parity_d    = ^holdData_q;
`endif
    end

    if (accept) begin
      holdValid_d = 1'b1;
      holdData_d  = data_in;
    end

    ready_d = !holdValid_q && !accept;
    busy_d  = holdValid_d || (state_d != IDLE);
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q     <= IDLE;
      timer_q     <= '0;
      idx_q       <= 3'd0;
      shift_q     <= 8'd0;
      holdData_q  <= 8'd0;
      holdValid_q <= 1'b0;
      txd_q       <= 1'b1;
      ready_q     <= 1'b0;
      busy_q      <= 1'b0;
`ifdef UART_TX_PARITY_EN
      parity_q    <= 1'b0;
`endif
    end else begin
      state_q     <= state_d;
      timer_q     <= timer_d;
      idx_q       <= idx_d;
      shift_q     <= shift_d;
      holdData_q  <= holdData_d;
      holdValid_q <= holdValid_d;
      txd_q       <= txd_d;
      ready_q     <= ready_d;
      busy_q      <= busy_d;
`ifdef UART_TX_PARITY_EN
      parity_q    <= parity_d;
`endif
    end
  end

  assign RsTx      = txd_q;
  assign ready_out = ready_q;
  assign busy      = busy_q;

endmodule

// File: tb/tb_uart_tx.sv
// tb_uart_tx: drives uart_tx with directed and random traffic and checks it against a
// frame-level model (line level derived from elapsed time since each frame start).
module tb_uart_tx;

  localparam int CLK_FREQ  = 100_000_000;
  localparam int BAUD_RATE = 3_000_000;
  localparam int DIV       = (CLK_FREQ + BAUD_RATE / 2) / BAUD_RATE;
`ifdef UART_TX_PARITY_EN
  localparam int NBITS      = 11;
  localparam int EXP_BUSY   = 364;
  localparam int EXP_GAP    = 363;
  localparam int EXP_RDYLOW = 362;
`else
  localparam int NBITS      = 10;
  localparam int EXP_BUSY   = 331;
  localparam int EXP_GAP    = 330;
  localparam int EXP_RDYLOW = 329;
`endif
  localparam int FRAME = NBITS * DIV;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       valid_in = 1'b0;
  logic [7:0] data_in = 8'd0;
  logic       ready_out, RsTx, busy;

  int nVec = 0;
  int nErr = 0;
  int cyc  = 0;

  // Model state: one pending byte plus the start cycle of the frame on the line.
  bit         mActive = 0, mHoldValid = 0, mReady = 0, mBusy = 0, mTx = 1, mAccepted = 0;
  int         mStart = 0;
  logic [7:0] mByte = 8'd0, mHoldByte = 8'd0;
  logic [7:0] expQ[$];
  logic [7:0] rxLog[$];
  logic       parLog[$];
  int         fallQ[$];

  logic        prevTx = 1'b1;
  bit          decActive = 0;
  int          decCnt = 0;
  logic [10:0] decBits = '0;

  uart_tx #(.CLK_FREQ(CLK_FREQ), .BAUD_RATE(BAUD_RATE)) dut (
    .clk      (clk),
    .rst      (rst),
    .data_in  (data_in),
    .valid_in (valid_in),
    .ready_out(ready_out),
    .RsTx     (RsTx),
    .busy     (busy)
  );

  always #5 clk = ~clk;

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    nVec++;
    if (act !== exp) begin
      nErr++;
      $display("[TB] FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic timeoutFail(input string name);
    nVec++;
    nErr++;
    $display("[TB] FAIL %s: timed out, awaited event never occurred (cycle %0d)", name, cyc);
  endtask

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  task automatic waitAccept(input string name);
    int n;
    n = 0;
    do begin
      tick();
      n++;
    end while (!mAccepted && n < 2000);
    if (!mAccepted) timeoutFail(name);
  endtask

  task automatic waitIdle(input string name);
    int n;
    n = 0;
    while (!(busy === 1'b0 && ready_out === 1'b1) && n < 2000) begin
      tick();
      n++;
    end
    if (n >= 2000) timeoutFail(name);
    repeat (3) tick();
  endtask

  function automatic logic frameBit(input logic [7:0] b, input int pos);
    if (pos == 0) return 1'b0;
    if (pos <= 8) return b[pos-1];
`ifdef UART_TX_PARITY_EN
    if (pos == 9) return ^b;
`endif
    return 1'b1;
  endfunction

  // Reference model, stepped on every rising edge from the inputs the DUT also sees.
  initial forever begin : model
    bit acc, holdPre;
    @(posedge clk);
    cyc++;
    mAccepted = 0;
    if (!rst) begin
      mActive = 0; mHoldValid = 0; mReady = 0; mBusy = 0; mTx = 1;
      expQ.delete();
    end else begin
      acc     = valid_in && mReady;
      holdPre = mHoldValid;
      if (mActive && (cyc - mStart) >= FRAME) mActive = 0;
      if (!mActive && mHoldValid) begin
        mActive = 1; mStart = cyc; mByte = mHoldByte; mHoldValid = 0;
        expQ.push_back(mHoldByte);
      end
      if (acc) begin
        mHoldValid = 1; mHoldByte = data_in;
      end
      mAccepted = acc;
      mReady    = !holdPre && !acc;
      mBusy     = mHoldValid || mActive;
      mTx       = mActive ? frameBit(mByte, (cyc - mStart) / DIV) : 1'b1;
    end
  end

  // Per-cycle compare plus a mid-bit sampling receiver on RsTx.
  initial forever begin : monitor
    @(negedge clk);
    if (cyc > 0)
      checkOutput("cycle {tx,ready,busy}", {29'd0, RsTx, ready_out, busy}, {29'd0, mTx, mReady, mBusy});
    if (!rst) begin
      decActive = 0;
      prevTx    = 1'b1;
    end else begin
      if (!decActive) begin
        if (prevTx === 1'b1 && RsTx === 1'b0) begin
          decActive = 1; decCnt = 0; decBits = '0;
          fallQ.push_back(cyc);
        end
      end else begin
        decCnt++;
      end
      if (decActive && (decCnt % DIV) == DIV / 2) begin
        decBits[decCnt / DIV] = RsTx;
        if (decCnt / DIV == NBITS - 1) begin
          logic [7:0] e;
          checkOutput("stop bit", 32'(decBits[NBITS-1]), 32'd1);
          if (expQ.size() == 0) begin
            checkOutput("unexpected frame", 32'(decBits[8:1]), 32'h100);
          end else begin
            e = expQ.pop_front();
            checkOutput("frame byte", 32'(decBits[8:1]), 32'(e));
`ifdef UART_TX_PARITY_EN
            checkOutput("parity bit", 32'(decBits[9]), 32'(^e));
            parLog.push_back(decBits[9]);
`endif
          end
          rxLog.push_back(decBits[8:1]);
          decActive = 0;
        end
      end
      prevTx = RsTx;
    end
  end

  initial begin : watchdog
    #3_000_000;
    $display("[TB] FAIL watchdog: simulation still running, expected to finish earlier");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic applyStimulus();
    int         base, n;
    logic       trace[0:399];
    logic [7:0] seq[5];
    logic [7:0] accBytes[$];
    logic [7:0] cur;

    // Reset held with a valid byte waiting: nothing may leave.
    rst = 1'b0; valid_in = 1'b1; data_in = 8'h3C;
    repeat (5) tick();
    checkOutput("reset RsTx", 32'(RsTx), 32'd1);
    checkOutput("reset ready", 32'(ready_out), 32'd0);
    checkOutput("reset busy", 32'(busy), 32'd0);
    checkOutput("reset no start bit", 32'(fallQ.size()), 32'd0);
    rst = 1'b1;
    tick();
    checkOutput("release ready", 32'(ready_out), 32'd1);
    checkOutput("release busy", 32'(busy), 32'd0);
    waitAccept("accept 3C");
    valid_in = 1'b0;
    waitIdle("idle after 3C");
    checkOutput("3C frame count", 32'(rxLog.size()), 32'd1);
    if (rxLog.size() > 0) checkOutput("3C value", 32'(rxLog[0]), 32'h3C);

    // Single 0x55: waveform points and busy length.
    data_in = 8'h55; valid_in = 1'b1;
    waitAccept("accept 55");
    valid_in = 1'b0;
    n = 0;
    while (busy === 1'b1 && n < 1000) begin
      if (n < 400) trace[n] = RsTx;
      n++;
      tick();
    end
    checkOutput("55 busy cycles", 32'(n), 32'(EXP_BUSY));
    checkOutput("55 idle before start", 32'(trace[0]), 32'd1);
    checkOutput("55 start first", 32'(trace[1]), 32'd0);
    checkOutput("55 start last", 32'(trace[33]), 32'd0);
    checkOutput("55 bit0 first", 32'(trace[34]), 32'd1);
    checkOutput("55 bit0 last", 32'(trace[66]), 32'd1);
    checkOutput("55 bit1 first", 32'(trace[67]), 32'd0);
    checkOutput("55 bit7", 32'(trace[297]), 32'd0);
    waitIdle("idle after 55");
    checkOutput("55 value", 32'(rxLog[$]), 32'h55);

    // Back-to-back 0x00 then 0xFF with valid held.
    fallQ.delete();
    data_in = 8'h00; valid_in = 1'b1;
    waitAccept("accept 00");
    data_in = 8'hFF;
    waitAccept("accept FF");
    valid_in = 1'b0;
    n = 0;
    while (ready_out === 1'b0 && n < 1000) begin
      n++;
      tick();
    end
    checkOutput("ready low until FF load", 32'(n), 32'(EXP_RDYLOW));
    waitIdle("idle after FF");
    checkOutput("b2b start count", 32'(fallQ.size()), 32'd2);
    if (fallQ.size() >= 2) checkOutput("b2b start gap", 32'(fallQ[1] - fallQ[0]), 32'(EXP_GAP));
    checkOutput("b2b last byte", 32'(rxLog[$]), 32'hFF);

    // Data changing every cycle: only bytes on ready edges go out.
    base = rxLog.size();
    valid_in = 1'b1;
    for (int i = 0; i < 700; i++) begin
      cur = 8'($urandom);
      data_in = cur;
      tick();
      if (mAccepted) accBytes.push_back(cur);
    end
    valid_in = 1'b0;
    waitIdle("idle after churn");
    checkOutput("churn frame count", 32'(rxLog.size() - base), 32'(accBytes.size()));
    for (int i = 0; i < accBytes.size() && base + i < rxLog.size(); i++)
      checkOutput("churn byte", 32'(rxLog[base+i]), 32'(accBytes[i]));

    // Reset during data bit 3 of 0xA5 with 0x5A held.
    data_in = 8'hA5; valid_in = 1'b1;
    waitAccept("accept A5");
    data_in = 8'h5A;
    waitAccept("accept 5A");
    valid_in = 1'b0;
    repeat (140) tick();
    checkOutput("A5 bit3 on line", 32'(RsTx), 32'd0);
    rst = 1'b0;
    tick();
    checkOutput("midframe reset RsTx", 32'(RsTx), 32'd1);
    checkOutput("midframe reset busy", 32'(busy), 32'd0);
    repeat (3) tick();
    rst = 1'b1;
    tick();
    base = rxLog.size();
    data_in = 8'h81; valid_in = 1'b1;
    waitAccept("accept 81");
    valid_in = 1'b0;
    waitIdle("idle after 81");
    checkOutput("post-reset frame count", 32'(rxLog.size() - base), 32'd1);
    if (rxLog.size() > base) checkOutput("post-reset byte", 32'(rxLog[base]), 32'h81);

    // Loopback sequence.
    seq = '{8'd5, 8'd0, 8'd7, 8'd0, 8'd255};
    base = rxLog.size();
    n = parLog.size();
    for (int i = 0; i < 5; i++) begin
      data_in = seq[i]; valid_in = 1'b1;
      waitAccept("accept loop byte");
    end
    valid_in = 1'b0;
    waitIdle("idle after loop");
    checkOutput("loop frame count", 32'(rxLog.size() - base), 32'd5);
    for (int i = 0; i < 5 && base + i < rxLog.size(); i++)
      checkOutput("loop byte", 32'(rxLog[base+i]), 32'(seq[i]));
`ifdef UART_TX_PARITY_EN
    if (parLog.size() > n + 2) checkOutput("07 parity", 32'(parLog[n+2]), 32'd1);
`endif

    // Random traffic with occasional resets.
    for (int i = 0; i < 3000; i++) begin
      if ($urandom_range(999) == 0) begin
        rst = 1'b0;
        tick();
        rst = 1'b1;
      end
      valid_in = ($urandom_range(3) == 0);
      data_in  = 8'($urandom);
      tick();
    end
    valid_in = 1'b0;
    waitIdle("idle after random");
  endtask

  initial begin
    applyStimulus();
    checkOutput("model queue drained", 32'(expQ.size()), 32'd0);
    $display("== %0d vectors applied, %0d miscompares ==", nVec, nErr);
    $finish;
  end

endmodule
